plic_claim_sched: RTL and testbench
===================================

Name: plic_claim_sched

Overview:
- Interrupt claim/complete scheduler for the platform interrupt controller.
- Consumes per-source enable and priority register contents from the controller's 32-bit enable/priority registers, plus the raw source lines.
- Holds per-source pending/in-service state and scans sources sequentially to find the highest-priority eligible interrupt.
- Drives the core's external interrupt line and serves the claim/complete handshake.

Parameters:
- NSRC, 32, number of source IDs including reserved ID 0 (legal range 2..32).
- PRIO_W, 3, priority field width; priority 0 means never interrupt.
- ID_W, $clog2(NSRC), width of source ID fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- src_irq  in  NSRC  level-sensitive source lines; bit 0 ignored.
- ie  in  NSRC  enable bits from the enable register; bit 0 ignored.
- prio  in  NSRC*PRIO_W  flattened priorities; source i occupies [i*PRIO_W +: PRIO_W].
- threshold  in  PRIO_W  priority threshold.
- claim_req  in  1  single-cycle claim strobe.
- claim_vld  out  1  claim response valid, one cycle.
- claim_id  out  ID_W  claimed ID; 0 means none.
- complete_req  in  1  single-cycle completion strobe.
- complete_id  in  ID_W  ID being completed.
- irq_o  out  1  external interrupt to core.
- pending_o  out  NSRC  pending bits, for the read-only pending register.

Behaviour:
- Reset (async, rst=1):
  - all pending and in-service bits cleared.
  - FSM goes to SCAN with idx=1; best_id=0 and best_prio=0.
  - claim_vld=0, claim_id=0, irq_o=0, pending_o=0.
- Gateway, per source i≥1:
  - pending sets on the clock edge where src_irq[i]=1, pending=0 and in-service=0.
  - Claim of i clears pending[i] and sets inservice[i] on the same edge.
  - Complete with complete_id==i and inservice[i]=1 clears inservice[i].
  - Completes for ID 0 or a non-in-service ID are ignored silently.
- Eligibility: pending[i] & ie[i] & (prio[i] > threshold).
- FSM states SCAN and HOLD:
  - SCAN: examine one index per cycle, idx 1..NSRC-1.
  - Candidate replaces the running max only when its priority is strictly greater, so ties go to the lower ID.
  - After idx=NSRC-1, the running result is copied to best_id/best_prio on that edge. The FSM then enters HOLD for one cycle and returns to SCAN with idx=1 and the running max cleared.
  - Full scan latency is NSRC-1 cycles, plus 1 HOLD cycle.
- irq_o = registered (best_id != 0); it updates the cycle after best_id updates.
- Claim (claim_req=1 at edge T):
  - At T+1: claim_vld=1.
  - claim_id = best_id if, sampled at T, pending[best_id] & ie[best_id] & prio[best_id] > threshold still holds; otherwise claim_id = 0.
  - A nonzero claim clears pending and sets in-service at edge T.
  - At edge T, best_id and irq_o are forced to 0 and the scan restarts at idx=1, with the running max cleared.
  - claim_req while claim_vld=1 is legal; it is served the next cycle against the already-reset best_id, so it returns 0 until the rescan completes.
- Claim and complete in the same cycle are both applied. If they name the same ID, the in-service bit ends set, because claim follows complete.
- Stale results: ie, prio or threshold changes during a scan are sampled per index. Correctness is restored by the next full scan; the claim-time recheck prevents claiming a now-ineligible source.
- prio field wider than threshold: none; both are PRIO_W and compared unsigned.
- Reset asserted mid-scan or mid-claim: everything returns to reset values; no claim_vld is produced for the aborted request.

Decomposition:
- Package plic_pkg:
  - NSRC, PRIO_W and ID_W defaults.
  - FSM state enum {SCAN, HOLD}.
  - Function prio_of(prio_flat, idx).
- Sub-module plic_gateway: one instance per source, holding pending/in-service flops and the set/claim/complete logic. It is generated for i=1..NSRC-1.
- Top level contains the scan FSM, the claim/complete handshake and the output registers.

Test Plan:
- Reset: assert rst mid-scan with src_irq=all ones -> all outputs 0 immediately (async); after release, no irq_o within NSRC-1 cycles if ie=0.
- Single source: ie[5]=1, prio[5]=3, threshold=1, pulse src_irq[5] -> pending_o[5]=1 next cycle; irq_o=1 within NSRC+2 cycles; claim -> claim_vld=1, claim_id=5 one cycle later, pending_o[5]=0, irq_o=0.
- Priority/tie: sources 3 and 7 at prio 4, source 9 at prio 6 -> claim returns 9. Complete 9, then claim -> 3, then claim -> 7.
- Threshold: source 4 at prio 2, threshold=2 -> irq_o stays 0. Set threshold=1 -> irq_o=1 after at most two scans.
- In-service gating: claim 6 with src_irq[6] held high -> pending_o[6] stays 0 until complete_id=6. complete_id=2 (not in service) has no effect. After complete, pending_o[6]=1 next cycle.
- Stale result and back-to-back: after irq_o=1 for source 8, clear ie[8] then claim -> claim_id=0. Two consecutive claim_req cycles -> the second returns 0.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared types, default sizes and helpers for the PLIC claim/complete scheduler.
package plic_pkg;

    localparam int unsigned NSRC_DEF   = 32;
    localparam int unsigned PRIO_W_DEF = 3;
    localparam int unsigned ID_W_DEF   = $clog2(NSRC_DEF);

    // Upper bounds used to give prio_of a fixed-width argument.
    localparam int unsigned MAX_NSRC    = 32;
    localparam int unsigned MAX_PRIO_W  = 8;
    localparam int unsigned PRIO_FLAT_W = MAX_NSRC * MAX_PRIO_W;

    typedef enum logic [0:0] {
        SCAN,
        HOLD
    } scan_state_e;

    // Extract the priority field of source idx from a zero-extended flattened vector.
    function automatic logic [MAX_PRIO_W-1:0] prio_of(input logic [PRIO_FLAT_W-1:0] prio_flat,
                                                      input int unsigned idx,
                                                      input int unsigned prio_w);
        logic [PRIO_FLAT_W-1:0] shifted;
        logic [MAX_PRIO_W-1:0]  mask;
        shifted = prio_flat >> (idx * prio_w);
        mask    = MAX_PRIO_W'((32'd1 << prio_w) - 32'd1);
        return shifted[MAX_PRIO_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: pending and in-service flops with set/claim/complete logic.
module plic_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    logic pending_q, pending_d;
    logic inservice_q, inservice_d;

    // A new request is only accepted while neither pending nor being serviced.
    always_comb begin
        pending_d   = pending_q;
        inservice_d = inservice_q;
        if (src && !pending_q && !inservice_q) begin
            pending_d = 1'b1;
        end
        if (complete && inservice_q) begin
            inservice_d = 1'b0;
        end
        // Claim applied after complete so a same-cycle pair leaves the source in service.
        if (claim) begin
            pending_d   = 1'b0;
            inservice_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= 1'b0;
            inservice_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/plic_claim_sched.sv
// Sequential priority scan plus claim/complete handshake for the external interrupt.
module plic_claim_sched
    import plic_pkg::*;
#(
    parameter int unsigned NSRC   = NSRC_DEF,
    parameter int unsigned PRIO_W = PRIO_W_DEF,
    parameter int unsigned ID_W   = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC-1:0]        src_irq,
    input  logic [NSRC-1:0]        ie,
    input  logic [NSRC*PRIO_W-1:0] prio,
    input  logic [PRIO_W-1:0]      threshold,
    input  logic                   claim_req,
    output logic                   claim_vld,
    output logic [ID_W-1:0]        claim_id,
    input  logic                   complete_req,
    input  logic [ID_W-1:0]        complete_id,
    output logic                   irq_o,
    output logic [NSRC-1:0]        pending_o
);

    localparam logic [ID_W-1:0] FIRST_IDX = ID_W'(1);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NSRC - 1);

    scan_state_e       state_q, state_d;
    logic [ID_W-1:0]   idx_q, idx_d;
    logic [ID_W-1:0]   run_id_q, run_id_d;
    logic [PRIO_W-1:0] run_prio_q, run_prio_d;
    logic [ID_W-1:0]   best_id_q, best_id_d;
    logic              claim_vld_q;
    logic [ID_W-1:0]   claim_id_q;
    logic              irq_q;

    logic [NSRC-1:0]        pending;
    logic [PRIO_FLAT_W-1:0] prio_ext;
    logic [PRIO_W-1:0]      cur_prio;
    logic [PRIO_W-1:0]      best_cur_prio;
    logic                   cand_win;
    logic                   claim_ok;
    logic                   unused_src0;

    assign prio_ext      = PRIO_FLAT_W'(prio);
    assign cur_prio      = PRIO_W'(prio_of(prio_ext, 32'(idx_q), PRIO_W));
    assign best_cur_prio = PRIO_W'(prio_of(prio_ext, 32'(best_id_q), PRIO_W));
    assign unused_src0   = src_irq[0];

    // Strictly-greater keeps the lower ID on ties since indices ascend.
    assign cand_win = pending[idx_q] && ie[idx_q] && (cur_prio > threshold)
                      && (cur_prio > run_prio_q);

    // Recheck the stored winner against live state so a stale result cannot be claimed.
    assign claim_ok = claim_req && (best_id_q != '0) && pending[best_id_q] && ie[best_id_q]
                      && (best_cur_prio > threshold);

    // ID 0 is reserved and never pending.
    assign pending[0] = 1'b0;

    for (genvar i = 1; i < NSRC; i++) begin : g_gw
        plic_gateway u_gw (
            .clk      (clk),
            .rst      (rst),
            .src      (src_irq[i]),
            .claim    (claim_ok && (best_id_q == ID_W'(i))),
            .complete (complete_req && (complete_id == ID_W'(i))),
            .pending  (pending[i])
        );
    end

    // Scan FSM next state: one index per cycle, publish at the last index, one HOLD cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        run_id_d   = run_id_q;
        run_prio_d = run_prio_q;
        best_id_d  = best_id_q;
        case (state_q)
            SCAN: begin
                if (cand_win) begin
                    run_id_d   = idx_q;
                    run_prio_d = cur_prio;
                end
                if (idx_q == LAST_IDX) begin
                    best_id_d  = cand_win ? idx_q : run_id_q;
                    run_id_d   = '0;
                    run_prio_d = '0;
                    idx_d      = FIRST_IDX;
                    state_d    = HOLD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            HOLD: begin
                state_d = SCAN;
            end
            default: begin
                state_d = SCAN;
            end
        endcase
        // Any claim invalidates the published winner and restarts the scan.
        if (claim_req) begin
            state_d    = SCAN;
            idx_d      = FIRST_IDX;
            run_id_d   = '0;
            run_prio_d = '0;
            best_id_d  = '0;
        end
    end

    // Scan FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            idx_q      <= FIRST_IDX;
            run_id_q   <= '0;
            run_prio_q <= '0;
            best_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            run_id_q   <= run_id_d;
            run_prio_q <= run_prio_d;
            best_id_q  <= best_id_d;
        end
    end

    // Registered claim response and interrupt line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            claim_vld_q <= 1'b0;
            claim_id_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            claim_vld_q <= claim_req;
            claim_id_q  <= claim_ok ? best_id_q : '0;
            irq_q       <= claim_req ? 1'b0 : (best_id_q != '0);
        end
    end

    assign claim_vld = claim_vld_q;
    assign claim_id  = claim_id_q;
    assign irq_o     = irq_q;
    assign pending_o = pending;

endmodule

// File: tb/tb_plic_claim_sched.sv
// Directed self-checking bench for plic_claim_sched (NSRC=32, PRIO_W=3).
module tb_plic_claim_sched;

    localparam int NSRC   = 32;
    localparam int PRIO_W = 3;
    localparam int ID_W   = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NSRC-1:0]        src_irq;
    logic [NSRC-1:0]        ie;
    logic [NSRC*PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]      threshold;
    logic                   claim_req;
    logic                   claim_vld;
    logic [ID_W-1:0]        claim_id;
    logic                   complete_req;
    logic [ID_W-1:0]        complete_id;
    logic                   irq_o;
    logic [NSRC-1:0]        pending_o;

    int n_checks = 0;
    int n_pass   = 0;

    plic_claim_sched dut (
        .clk          (clk),
        .rst          (rst),
        .src_irq      (src_irq),
        .ie           (ie),
        .prio         (prio),
        .threshold    (threshold),
        .claim_req    (claim_req),
        .claim_vld    (claim_vld),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .irq_o        (irq_o),
        .pending_o    (pending_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release lands just after an edge, so the next posedge is the first scan step (idx 1).
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_inputs();
        src_irq      = '0;
        ie           = '0;
        prio         = '0;
        threshold    = '0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;
    endtask

    task automatic set_prio(input int idx, input int val);
        prio[idx*PRIO_W +: PRIO_W] = PRIO_W'(val);
    endtask

    task automatic wait_irq(input int bound, output int cycles);
        cycles = 0;
        while (!irq_o && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_claim(input string tag, input logic [31:0] exp_id);
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check_eq({tag, "_vld"}, 32'(claim_vld), 32'd1);
        check_eq({tag, "_id"}, 32'(claim_id), exp_id);
    endtask

    task automatic do_complete(input int id);
        complete_req = 1'b1;
        complete_id  = ID_W'(id);
        tick();
        complete_req = 1'b0;
        complete_id  = '0;
    endtask

    initial begin
        int  cyc;
        logic seen;

        clear_inputs();
        do_reset();
        check_eq("rst_irq", 32'(irq_o), 32'd0);
        check_eq("rst_vld", 32'(claim_vld), 32'd0);
        check_eq("rst_pending", pending_o, 32'd0);

        // Reset mid-claim with every source active.
        src_irq = '1;
        ie      = '1;
        for (int i = 0; i < NSRC; i++) set_prio(i, 1);
        do_reset();
        wait_irq(40, cyc);
        check_eq("all_irq_up", 32'(irq_o), 32'd1);
        claim_req = 1'b1;
        #3 rst = 1'b1;
        #1;
        check_eq("async_irq", 32'(irq_o), 32'd0);
        check_eq("async_pending", pending_o, 32'd0);
        check_eq("async_vld", 32'(claim_vld), 32'd0);
        check_eq("async_id", 32'(claim_id), 32'd0);
        claim_req = 1'b0;
        tick();
        check_eq("aborted_vld", 32'(claim_vld), 32'd0);
        ie  = '0;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < NSRC - 1; i++) begin
            tick();
            seen |= irq_o;
        end
        check_eq("ie0_no_irq", 32'(seen), 32'd0);
        check_eq("ie0_pending", pending_o, 32'hFFFF_FFFE);

        // Single source 5.
        clear_inputs();
        ie[5]      = 1'b1;
        set_prio(5, 3);
        threshold  = 3'd1;
        src_irq[5] = 1'b1;
        do_reset();
        tick();
        src_irq = '0;
        check_eq("s5_pending", pending_o, 32'h0000_0020);
        wait_irq(NSRC + 2, cyc);
        check_eq("s5_irq", 32'(irq_o), 32'd1);
        check_eq("s5_latency", 32'(cyc), 32'd31);
        do_claim("s5_claim", 32'd5);
        check_eq("s5_pend_clr", pending_o, 32'd0);
        check_eq("s5_irq_clr", 32'(irq_o), 32'd0);
        tick();
        check_eq("s5_vld_pulse", 32'(claim_vld), 32'd0);

        // Priority and tie-break.
        clear_inputs();
        ie[3] = 1'b1; ie[7] = 1'b1; ie[9] = 1'b1;
        set_prio(3, 4); set_prio(7, 4); set_prio(9, 6);
        src_irq[3] = 1'b1; src_irq[7] = 1'b1; src_irq[9] = 1'b1;
        do_reset();
        tick();
        src_irq = '0;
        wait_irq(NSRC + 2, cyc);
        do_claim("pr_9", 32'd9);
        do_complete(9);
        wait_irq(2 * NSRC + 4, cyc);
        do_claim("pr_3", 32'd3);
        wait_irq(2 * NSRC + 4, cyc);
        do_claim("pr_7", 32'd7);
        check_eq("pr_pending", pending_o, 32'd0);

        // Threshold gating.
        clear_inputs();
        ie[4] = 1'b1;
        set_prio(4, 2);
        threshold  = 3'd2;
        src_irq[4] = 1'b1;
        do_reset();
        tick();
        src_irq = '0;
        seen = 1'b0;
        for (int i = 0; i < 2 * NSRC + 4; i++) begin
            tick();
            seen |= irq_o;
        end
        check_eq("th_blocked", 32'(seen), 32'd0);
        threshold = 3'd1;
        wait_irq(2 * NSRC + 2, cyc);
        check_eq("th_irq", 32'(irq_o), 32'd1);

        // In-service gating with the line held high.
        clear_inputs();
        ie[6] = 1'b1;
        set_prio(6, 5);
        src_irq[6] = 1'b1;
        do_reset();
        wait_irq(NSRC + 4, cyc);
        do_claim("is_6", 32'd6);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= pending_o[6];
        end
        do_complete(2);
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= pending_o[6];
        end
        check_eq("is_held", 32'(seen), 32'd0);
        do_complete(6);
        tick();
        check_eq("is_repend", 32'(pending_o[6]), 32'd1);

        // Stale winner and back-to-back claims.
        clear_inputs();
        ie[8] = 1'b1;
        set_prio(8, 2);
        src_irq[8] = 1'b1;
        do_reset();
        tick();
        src_irq = '0;
        wait_irq(NSRC + 2, cyc);
        check_eq("st_irq", 32'(irq_o), 32'd1);
        ie[8] = 1'b0;
        tick();
        do_claim("st_stale", 32'd0);
        check_eq("st_still_pend", pending_o, 32'h0000_0100);
        ie[8] = 1'b1;
        wait_irq(2 * NSRC + 4, cyc);
        claim_req = 1'b1;
        tick();
        check_eq("b2b_first", 32'(claim_id), 32'd8);
        tick();
        claim_req = 1'b0;
        check_eq("b2b_vld", 32'(claim_vld), 32'd1);
        check_eq("b2b_second", 32'(claim_id), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
